// File: rtl/serial_cla_sequencer.sv
// Nibble-serial adder: one 4-bit carry-lookahead adder reused per nibble.
// Operands are captured on accept; the result is presented until consumed.

module carry_lookahead_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Generate/propagate terms and flattened lookahead carries
    always_comb begin
        g    = A & B;
        p    = A ^ B;
        c[0] = Cin;
        c[1] = g[0] | (p[0] & Cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & Cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & Cin);
        S    = p ^ c[3:0];
        Cout = c[4];
    end

endmodule

module serial_cla_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf,
    output logic                 busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic [IW-1:0] idx_q, idx_d;

    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [3:0]    s_nib;
    logic          c_nib;
    logic          accept;
    logic          last;

    assign accept = in_valid && (state_q == IDLE);
    assign last   = (idx_q == IW'(NIBBLES - 1));

    // Select the operand nibble addressed by the current index
    always_comb begin
        a_nib = 4'h0;
        b_nib = 4'h0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx_q == IW'(n)) begin
                a_nib = a_q[4*n +: 4];
                b_nib = b_q[4*n +: 4];
            end
        end
    end

    carry_lookahead_adder u_cla (
        .A    (a_nib),
        .B    (b_nib),
        .Cin  (carry_q),
        .S    (s_nib),
        .Cout (c_nib)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN:  if (last) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    // Datapath next-state: capture, per-nibble accumulate, final flags
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                end
            end
            RUN: begin
                for (int n = 0; n < NIBBLES; n++) begin
                    if (idx_q == IW'(n)) begin
                        sum_d[4*n +: 4] = s_nib;
                    end
                end
                carry_d = c_nib;
                // Index saturates on the last nibble so it never wraps
                if (last) begin
                    cout_d = c_nib;
                    ovf_d  = (a_nib[3] ^ b_nib[3] ^ s_nib[3]) ^ c_nib;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_cla_sequencer.sv
// Directed and randomized checks for the nibble-serial adder.
// Expected values are hand-computed or derived from a 17-bit reference add.

module tb_serial_cla_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    int checks;
    int failures;

    serial_cla_sequencer #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request while idle; returns 1 ns after the accepting edge
    task automatic accept(input logic [15:0] ta, input logic [15:0] tb_,
                          input logic tc);
        a        = ta;
        b        = tb_;
        cin      = tc;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0;
        b         = 16'h0;
        cin       = 1'b0;
        #3;
        checks++;
        if ({in_ready, out_valid, busy, sum, cout, ovf} !== {3'b100, 16'h0, 2'b00}) begin
            failures++;
            $display("FAIL reset_state got rdy=%b vld=%b busy=%b sum=%h c=%b o=%b",
                     in_ready, out_valid, busy, sum, cout, ovf);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_carry_chain;
        out_ready = 1'b1;
        accept(16'hFFFF, 16'h0001, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== (k == 4)) begin
                failures++;
                $display("FAIL chain_latency edge=%0d out_valid=%b want=%b",
                         k, out_valid, (k == 4));
            end
        end
        checks++;
        if ({cout, sum, ovf} !== {1'b1, 16'h0000, 1'b0}) begin
            failures++;
            $display("FAIL chain_result got c=%b sum=%h o=%b want c=1 sum=0000 o=0",
                     cout, sum, ovf);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, busy, cout, sum} !== {3'b100, 1'b1, 16'h0}) begin
            failures++;
            $display("FAIL chain_idle_retain rdy=%b vld=%b busy=%b c=%b sum=%h",
                     in_ready, out_valid, busy, cout, sum);
        end
    endtask

    task automatic test_overflow;
        out_ready = 1'b1;
        accept(16'h7FFF, 16'h0001, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, sum, cout, ovf} !== {1'b1, 16'h8000, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL ovf_pos got v=%b sum=%h c=%b o=%b want v=1 8000 c=0 o=1",
                     out_valid, sum, cout, ovf);
        end
        @(posedge clk);
        #1;
        accept(16'h8000, 16'h8000, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, sum, cout, ovf} !== {1'b1, 16'h0000, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL ovf_neg got v=%b sum=%h c=%b o=%b want v=1 0000 c=1 o=1",
                     out_valid, sum, cout, ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_operand_change;
        out_ready = 1'b1;
        accept(16'h1234, 16'h4321, 1'b1);
        a   = 16'hFFFF;
        b   = 16'hFFFF;
        cin = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, sum, cout, ovf} !== {1'b1, 16'h5556, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL operand_change got v=%b sum=%h c=%b o=%b want v=1 5556 c=0 o=0",
                     out_valid, sum, cout, ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_done_hold;
        out_ready = 1'b0;
        accept(16'h0F0F, 16'h0101, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        a        = 16'hAAAA;
        b        = 16'h5555;
        cin      = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({out_valid, in_ready, busy, sum, cout, ovf} !==
                {3'b101, 16'h1010, 2'b00}) begin
                failures++;
                $display("FAIL done_hold cyc=%0d v=%b rdy=%b busy=%b sum=%h c=%b o=%b",
                         k, out_valid, in_ready, busy, sum, cout, ovf);
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, busy, sum} !== {3'b100, 16'h1010}) begin
            failures++;
            $display("FAIL done_release rdy=%b v=%b busy=%b sum=%h want 1 0 0 1010",
                     in_ready, out_valid, busy, sum);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL done_no_queue busy=%b want 0", busy);
        end
    endtask

    task automatic test_mid_reset;
        int seen;
        out_ready = 1'b1;
        accept(16'h1111, 16'h2222, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, sum, cout, ovf} !== {3'b100, 16'h0, 2'b00}) begin
            failures++;
            $display("FAIL midrun_reset rdy=%b v=%b busy=%b sum=%h c=%b o=%b",
                     in_ready, out_valid, busy, sum, cout, ovf);
        end
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL abort_no_valid out_valid_cycles=%0d want 0", seen);
        end
        accept(16'hABCD, 16'h1234, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, sum, cout, ovf} !== {1'b1, 16'hBE01, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL post_reset got v=%b sum=%h c=%b o=%b want v=1 be01 c=0 o=0",
                     out_valid, sum, cout, ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [16:0] ref_sum;
        logic        ref_ovf;
        int          lat;
        int          dly;
        int          bad_lat;
        int          bad_res;
        int          bad_hs;
        bad_lat = 0;
        bad_res = 0;
        bad_hs  = 0;
        for (int it = 0; it < 1000; it++) begin
            ra        = 16'($urandom);
            rb        = 16'($urandom);
            rc        = 1'($urandom_range(0, 1));
            dly       = $urandom_range(0, 3);
            out_ready = (dly == 0);
            ref_sum   = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
            ref_ovf   = (ra[15] == rb[15]) && (ref_sum[15] != ra[15]);
            accept(ra, rb, rc);
            a   = 16'($urandom);
            b   = 16'($urandom);
            lat = 0;
            while (!out_valid && lat < 10) begin
                @(posedge clk);
                #1;
                lat++;
            end
            if (lat != 4 && bad_lat < 5) begin
                $display("FAIL rand_latency it=%0d lat=%0d want 4", it, lat);
            end
            if (lat != 4) bad_lat++;
            if ({cout, sum, ovf} !== {ref_sum, ref_ovf}) begin
                if (bad_res < 5)
                    $display("FAIL rand_result it=%0d %h+%h+%b got c=%b sum=%h o=%b want c=%b sum=%h o=%b",
                             it, ra, rb, rc, cout, sum, ovf,
                             ref_sum[16], ref_sum[15:0], ref_ovf);
                bad_res++;
            end
            if (dly != 0) begin
                repeat (dly) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
            @(posedge clk);
            #1;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                if (bad_hs < 5)
                    $display("FAIL rand_handshake it=%0d rdy=%b v=%b", it, in_ready, out_valid);
                bad_hs++;
                rst = 1'b1;
                #1;
                rst = 1'b0;
            end
        end
        checks += 3;
        if (bad_lat != 0) failures++;
        if (bad_res != 0) failures++;
        if (bad_hs != 0) failures++;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_carry_chain();
        test_overflow();
        test_operand_change();
        test_done_hold();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
